// File: rtl/apb_pkg.sv
// Shared types for the APB command master: width defaults, FSM state
// encoding and command/response record layouts.
package apb_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 8;

  // The encoding is fixed so that the debug state port can be decoded by hand.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  typedef struct packed {
    logic                      write;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] rdata;
    logic                      err;
  } rsp_t;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Bundle of the command channel, response channel and APB requester signals
// of apb_cmd_master. The master modport is the block's view of the bundle, and
// the slave modport is the view of everything around it.
//
// Handshake rule for cmd_* and rsp_*: a transfer happens on a rising PCLK edge
// where valid && ready. Once valid is raised, the payload stays stable until
// that edge. Ready may be raised before valid.
interface apb_cmd_master_if
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB requester. It accepts one command, runs the APB
// setup/access phases, and returns a response. Every output is a flop.
// Optional feature: define APB_CMD_MASTER_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES PREADY-low access samples. The abort is reported with rsp_err=1.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_cmd_master_if.master   bus,
  output state_e             dbg_state
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be at least 2");
  end

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state and next-output logic. SETUP raises PSEL. The first ACCESS cycle
  // raises PENABLE. PREADY is only looked at once PENABLE is already high.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_ready_q && bus.cmd_valid) begin
          cmd_ready_d = 1'b0;
          paddr_d     = bus.cmd_addr;
          pwrite_d    = bus.cmd_write;
          pwdata_d    = bus.cmd_write ? bus.cmd_wdata : '0;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b0;
        state_d   = ST_ACCESS;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end

      ST_ACCESS: begin
        if (!penable_q) begin
          penable_d = 1'b1;
        end else if (bus.PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_LAST) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        psel_d = 1'b0;
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, which are cleared immediately by reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  // Access watchdog counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master. It contains a small APB slave model
// (memory, programmable PREADY delay, optional PREADY tie-low).
// When APB_CMD_MASTER_TIMEOUT_EN is defined, it exercises the timeout abort.
// Otherwise it exercises a long PREADY wait.
module tb_apb_cmd_master;
  import apb_pkg::*;

  logic   PCLK;
  logic   PRESETn;
  state_e dbg_state;
  int     cyc;

  apb_cmd_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  apb_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---------------- APB slave model ----------------
  logic [31:0] mem [256];
  int          wait_cnt;
  int          ready_delay;
  logic        tie_low;

  assign bus.PREADY = bus.PSEL && bus.PENABLE && !tie_low && (wait_cnt >= ready_delay);
  assign bus.PRDATA = (bus.PSEL && bus.PENABLE) ? mem[bus.PADDR] : 32'hCAFE_F00D;

  always @(posedge PCLK) begin
    if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) mem[bus.PADDR] <= bus.PWDATA;
    if (bus.PSEL && bus.PENABLE && !bus.PREADY) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // ---------------- PSEL low-gap monitor ----------------
  bit mon_en;
  bit seen_high;
  int low_run;
  int min_gap;

  always @(negedge PCLK) begin
    if (mon_en) begin
      if (bus.PSEL) begin
        if (seen_high && low_run > 0 && low_run < min_gap) min_gap = low_run;
        seen_high = 1'b1;
        low_run   = 0;
      end else begin
        low_run++;
      end
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Presents a command and returns the cycle number of the accepting edge.
  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input bit keep_valid, output int t_acc);
    int guard;
    guard         = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("cmd_ready_wait", bus.cmd_ready, 1'b1);
    tick();
    t_acc = cyc;
    if (!keep_valid) bus.cmd_valid = 1'b0;
  endtask

  // Waits for a response, captures it, then completes the handshake on the next edge.
  task automatic wait_rsp(output int t_rsp, output logic [31:0] rdata, output logic err);
    int   guard;
    logic old_ready;
    guard = 0;
    while (!bus.rsp_valid && guard < 100) begin
      tick();
      guard++;
    end
    check("rsp_valid_wait", bus.rsp_valid, 1'b1);
    t_rsp         = cyc;
    rdata         = bus.rsp_rdata;
    err           = bus.rsp_err;
    old_ready     = bus.rsp_ready;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = old_ready;
    check("rsp_valid_drop", bus.rsp_valid, 1'b0);
    check("cmd_ready_back", bus.cmd_ready, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          t_acc, t_prev, t_rsp;
    logic [31:0] rdata;
    logic        err;
    logic        b2b_w [3];
    logic [7:0]  b2b_a [3];
    logic [31:0] b2b_d [3];
    logic [31:0] b2b_exp [3];

    n_cmp = 0; n_fail = 0;
    ready_delay = 0; tie_low = 1'b0;
    mon_en = 1'b0; seen_high = 1'b0; low_run = 0; min_gap = 1000;
    PRESETn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_psel", bus.PSEL, 1'b0);
    check("rst_penable", bus.PENABLE, 1'b0);
    check("rst_pwrite", bus.PWRITE, 1'b0);
    check("rst_paddr", bus.PADDR, 8'h00);
    check("rst_pwdata", bus.PWDATA, 32'h0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    PRESETn = 1'b1;
    tick();

    // Write 0xDEADBEEF to 0x10 and step through the APB phases
    send_cmd(1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0, t_acc);
    check("wr_n_psel", bus.PSEL, 1'b0);
    check("wr_n_cmd_ready", bus.cmd_ready, 1'b0);
    check("wr_n_paddr", bus.PADDR, 8'h10);
    check("wr_n_pwrite", bus.PWRITE, 1'b1);
    check("wr_n_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
    tick();
    check("wr_n1_psel", bus.PSEL, 1'b1);
    check("wr_n1_penable", bus.PENABLE, 1'b0);
    tick();
    check("wr_n2_psel", bus.PSEL, 1'b1);
    check("wr_n2_penable", bus.PENABLE, 1'b1);
    check("wr_n2_paddr", bus.PADDR, 8'h10);
    wait_rsp(t_rsp, rdata, err);
    check("wr_latency", t_rsp - t_acc, 3);
    check("wr_err", err, 1'b0);
    check("wr_rdata", rdata, 32'h0);

    // Read 0x10 back; PWDATA is zeroed for reads
    send_cmd(1'b0, 8'h10, 32'h1234_5678, 1'b0, t_acc);
    check("rd_pwdata_zero", bus.PWDATA, 32'h0);
    check("rd_pwrite", bus.PWRITE, 1'b0);
    wait_rsp(t_rsp, rdata, err);
    check("rd_latency", t_rsp - t_acc, 3);
    check("rd_err", err, 1'b0);
    check("rd_rdata", rdata, 32'hDEAD_BEEF);

    // Back-to-back commands with cmd_valid and rsp_ready held high
    b2b_w[0] = 1'b1; b2b_a[0] = 8'hFF; b2b_d[0] = 32'h0000_0001; b2b_exp[0] = 32'h0;
    b2b_w[1] = 1'b0; b2b_a[1] = 8'hFF; b2b_d[1] = 32'h0;         b2b_exp[1] = 32'h0000_0001;
    b2b_w[2] = 1'b1; b2b_a[2] = 8'h00; b2b_d[2] = 32'h0;         b2b_exp[2] = 32'h0;
    bus.rsp_ready = 1'b1;
    mon_en = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      send_cmd(b2b_w[i], b2b_a[i], b2b_d[i], (i < 2), t_acc);
      if (i > 0) check($sformatf("b2b_spacing_%0d", i), t_acc - t_prev, 5);
      t_prev = t_acc;
      wait_rsp(t_rsp, rdata, err);
      check($sformatf("b2b_latency_%0d", i), t_rsp - t_acc, 3);
      check($sformatf("b2b_err_%0d", i), err, 1'b0);
      check($sformatf("b2b_rdata_%0d", i), rdata, b2b_exp[i]);
    end
    tick();
    mon_en = 1'b0;
    bus.rsp_ready = 1'b0;
    check("b2b_psel_gap_ge2", (min_gap >= 2), 1'b1);

    // Response backpressure: rsp_ready low for 10 cycles
    send_cmd(1'b0, 8'h10, 32'h0, 1'b0, t_acc);
    for (int g = 0; g < 10 && !bus.rsp_valid; g++) tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", bus.rsp_valid, 1'b1);
      check("bp_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      check("bp_cmd_ready", bus.cmd_ready, 1'b0);
      check("bp_psel", bus.PSEL, 1'b0);
      tick();
    end
    wait_rsp(t_rsp, rdata, err);
    check("bp_rdata", rdata, 32'hDEAD_BEEF);
    check("bp_err", err, 1'b0);

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // PREADY tied low: abort after 16 PENABLE-high samples (accept N -> rsp N+18)
    tie_low = 1'b1;
    send_cmd(1'b0, 8'h10, 32'h0, 1'b0, t_acc);
    wait_rsp(t_rsp, rdata, err);
    check("tmo_err", err, 1'b1);
    check("tmo_rdata", rdata, 32'h0);
    check("tmo_latency", t_rsp - t_acc, 18);
    tie_low = 1'b0;
    send_cmd(1'b0, 8'h10, 32'h0, 1'b0, t_acc);
    wait_rsp(t_rsp, rdata, err);
    check("post_tmo_err", err, 1'b0);
    check("post_tmo_rdata", rdata, 32'hDEAD_BEEF);
    check("post_tmo_latency", t_rsp - t_acc, 3);
`else
    // PREADY delayed 40 access cycles: no abort (accept N -> rsp N+43)
    ready_delay = 40;
    send_cmd(1'b0, 8'h10, 32'h0, 1'b0, t_acc);
    wait_rsp(t_rsp, rdata, err);
    check("slow_err", err, 1'b0);
    check("slow_rdata", rdata, 32'hDEAD_BEEF);
    check("slow_latency", t_rsp - t_acc, 43);
    ready_delay = 0;
`endif

    // Reset pulsed during ACCESS
    ready_delay = 20;
    send_cmd(1'b1, 8'h20, 32'h1111_1111, 1'b0, t_acc);
    tick();
    tick();
    check("mid_penable_pre", bus.PENABLE, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    check("mid_rst_psel", bus.PSEL, 1'b0);
    check("mid_rst_penable", bus.PENABLE, 1'b0);
    check("mid_rst_pwrite", bus.PWRITE, 1'b0);
    check("mid_rst_paddr", bus.PADDR, 8'h00);
    check("mid_rst_pwdata", bus.PWDATA, 32'h0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    tick();
    PRESETn = 1'b1;
    ready_delay = 0;
    send_cmd(1'b1, 8'h20, 32'h5A5A_5A5A, 1'b0, t_acc);
    wait_rsp(t_rsp, rdata, err);
    check("post_rst_wr_err", err, 1'b0);
    check("post_rst_wr_latency", t_rsp - t_acc, 3);
    send_cmd(1'b0, 8'h20, 32'h0, 1'b0, t_acc);
    wait_rsp(t_rsp, rdata, err);
    check("post_rst_rd_rdata", rdata, 32'h5A5A_5A5A);
    check("post_rst_rd_err", err, 1'b0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
